ir_tx_arbiter: RTL and testbench
================================

// Module: ir_tx_arbiter
// PURPOSE
//  Shares one ir_send NEC transmitter between N_REQ requesters. Picks a requester,
//  latches its addr/cmd and drives the transmitter for one fixed frame slot.
//  Then forces an idle gap and acknowledges the requester. Sits between
//  application logic (buttons, UART bridge, ...) and ir_send.addr/cmd/ir_send.
// PARAMETERS
//  CLK_HZ    100_000_000  system clock frequency, Hz
//  N_REQ     4            number of requesters, 2..8
//  FRAME_MS  108          NEC frame period: slot length during which tx_en is held high
//  GAP_CYC   16           minimum tx_en-low cycles between slots, >=1
// PORTS
//  clk        in   1          system clock, all logic on posedge
//  rst        in   1          synchronous, active-high reset
//  req        in   N_REQ      request level per requester; held until its done pulse
//  req_addr   in   8*N_REQ    NEC address, requester i in [8*i+7:8*i]
//  req_cmd    in   8*N_REQ    NEC command, requester i in [8*i+7:8*i]
//  grant      out  N_REQ      one-hot, high for the whole slot of the granted requester
//  done       out  N_REQ      one-cycle pulse to requester i when its frame slot ends
//  tx_addr    out  8          to ir_send.addr; stable for the whole slot
//  tx_cmd     out  8          to ir_send.cmd; stable for the whole slot
//  tx_en      out  1          to ir_send.ir_send; high for exactly SLOT_CYC cycles per frame
//  busy       out  1          high in every state except IDLE
// BEHAVIOUR
//  SLOT_CYC = (CLK_HZ/1000)*FRAME_MS. The slot counter is $clog2(SLOT_CYC+1) bits wide.
//    Default SLOT_CYC is 10_800_000 (24 bits).
//  Reset: state=IDLE; grant, done, tx_addr, tx_cmd, tx_en and busy are all 0;
//    round-robin pointer=0; counters=0.
//  FSM IDLE -> LOAD -> SEND -> GAP -> IDLE:
//   IDLE: if any req bit is high, select the winner idx and go to LOAD. Otherwise stay.
//   LOAD (1 cycle): register tx_addr/tx_cmd from the winner's slice; grant[idx]<=1.
//     Clear the counter.
//   SEND: tx_en=1, counting from the first SEND cycle. After SLOT_CYC cycles:
//     tx_en<=0, grant<=0, done[idx] pulses for 1 cycle, go to GAP.
//   GAP: tx_en=0 for GAP_CYC cycles, then go to IDLE.
//  Latency: req rising in IDLE gives grant 1 cycle later (LOAD registered).
//    tx_en follows 2 cycles after the req rise.
//  Arbitration is round-robin. The search starts at ptr, wrapping from N_REQ-1 to 0.
//    After each grant, ptr <= idx+1 (mod N_REQ).
//  Requests are sampled only in IDLE. A req dropped mid-slot does not abort: the frame
//    completes and done still pulses. A req raised mid-slot waits.
//  A requester still asserting req after done is re-eligible at the next IDLE.
//    It is fairly ordered behind the other pending requesters.
//  req_addr/req_cmd changes after LOAD are ignored (values are latched).
//  rst mid-slot: on the next edge tx_en drops to 0, no done is issued, and the FSM returns to IDLE.
//  Minimum tx_en low time between frames is GAP_CYC+2 cycles.
// CONFIGURATION
//  IR_ARB_FIXED_PRIO_EN defined: fixed priority; the lowest set req index always wins
//    and ptr is unused and held at 0.
//  Not defined (default): round-robin as above. Ports and timing are identical in both modes.
// STRUCTURE
//  Shared package ir_pkg: NEC_BITS=8, NEC_FRAME_MS=108, and the state encodings
//    ST_IDLE/ST_LOAD/ST_SEND/ST_GAP (2-bit localparams).
//  One sub-module: rr_pick (N param; inputs req, ptr; outputs the one-hot winner and idx).
//    It is purely combinational. Under IR_ARB_FIXED_PRIO_EN it is called with ptr tied to 0.
//  The FSM, counters and output registers stay in ir_tx_arbiter.
// TESTING  (sim params CLK_HZ=1_000_000, FRAME_MS=1 -> SLOT_CYC=1000, GAP_CYC=16, N_REQ=4)
//  1 Reset: rst high 3 cycles with req=4'hF -> all outputs 0, state IDLE. First grant
//    after rst falls is grant=4'b0001.
//  2 Single req[2]=1, addr 8'h10 / cmd 8'hD8 -> grant=4'b0100 next cycle.
//    tx_en high exactly 1000 cycles with tx_addr=8'h10, tx_cmd=8'hD8.
//    done[2] is a 1-cycle pulse, then tx_en is low for >=18 cycles.
//  3 req=4'hF held continuously -> grant order 0,1,2,3,0. Each slot is exactly 1000 cycles.
//    No two grant bits are ever high at once.
//  4 req[1] held; req[0] raised mid-slot -> the slot for 1 finishes.
//    Next grant is 2'b... index 2 wins if pending, else index 0; never index 1 twice
//    while 0 waits.
//  5 Drop req[3] and change req_addr[3] mid-slot -> tx_addr is unchanged and the slot
//    completes; done[3] pulses.
//  6 Assert rst at cycle 500 of SEND -> tx_en=0 next edge, no done pulse, busy=0.
//    With IR_ARB_FIXED_PRIO_EN and req=4'b1010 held, grant goes to index 1 on every slot.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared IR transmit constants: NEC field width, frame period and arbiter FSM encodings.
package ir_pkg;

  localparam int NEC_BITS     = 8;
  localparam int NEC_FRAME_MS = 108;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

endpackage

// File: rtl/ir_tx_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker; the search starts at ptr and wraps.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     winner,
  output logic [IDX_W-1:0] idx
);

  localparam int PW = IDX_W + 1;

  logic [PW-1:0]    pos_s;
  logic [IDX_W-1:0] cand_s;
  logic             found_s;

  // Walk N candidates from ptr; the first requesting one wins.
  always_comb begin
    winner  = '0;
    idx     = '0;
    found_s = 1'b0;
    pos_s   = '0;
    cand_s  = '0;
    for (int k = 0; k < N; k++) begin
      pos_s = {1'b0, ptr} + PW'(k);
      if (pos_s >= PW'(N)) begin
        pos_s = pos_s - PW'(N);
      end else begin
        pos_s = pos_s;
      end
      cand_s = pos_s[IDX_W-1:0];
      if (!found_s && req[cand_s]) begin
        found_s        = 1'b1;
        idx            = cand_s;
        winner[cand_s] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/ir_tx_arbiter.sv
// ir_tx_arbiter: shares one NEC transmitter among N_REQ requesters, one fixed slot per grant.
// Define IR_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module ir_tx_arbiter
  import ir_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int N_REQ    = 4,
  parameter int FRAME_MS = NEC_FRAME_MS,
  parameter int GAP_CYC  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [NEC_BITS*N_REQ-1:0] req_addr,
  input  logic [NEC_BITS*N_REQ-1:0] req_cmd,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          done,
  output logic [NEC_BITS-1:0]       tx_addr,
  output logic [NEC_BITS-1:0]       tx_cmd,
  output logic                      tx_en,
  output logic                      busy
);

  localparam int SLOT_CYC = (CLK_HZ / 1000) * FRAME_MS;
  localparam int CNT_W    = $clog2(SLOT_CYC + 1);
  localparam int GAP_W    = $clog2(GAP_CYC + 1);
  localparam int IDX_W    = $clog2(N_REQ);

  logic [1:0]          state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [GAP_W-1:0]    gap_r;
  logic [IDX_W-1:0]    ptr_r;
  logic [N_REQ-1:0]    grant_r;
  logic [N_REQ-1:0]    done_r;
  logic [NEC_BITS-1:0] tx_addr_r;
  logic [NEC_BITS-1:0] tx_cmd_r;
  logic                tx_en_r;
  logic                busy_r;

  logic [N_REQ-1:0]    pick_onehot_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic [IDX_W-1:0]    ptr_next_s;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_r),
    .winner (pick_onehot_s),
    .idx    (pick_idx_s)
  );

  // Pointer advance; in fixed-priority builds it stays at 0 so the picker favours index 0.
  always_comb begin
`ifdef IR_ARB_FIXED_PRIO_EN
    ptr_next_s = '0;
`else
    if (pick_idx_s == IDX_W'(N_REQ - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = pick_idx_s + IDX_W'(1);
    end
`endif
  end

  // Slot FSM with all outputs registered; grant and tx fields are captured on entry to LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      gap_r     <= '0;
      ptr_r     <= '0;
      grant_r   <= '0;
      done_r    <= '0;
      tx_addr_r <= '0;
      tx_cmd_r  <= '0;
      tx_en_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      done_r <= '0;
      case (state_r)
        ST_IDLE: begin
          if (|req) begin
            state_r   <= ST_LOAD;
            busy_r    <= 1'b1;
            grant_r   <= pick_onehot_s;
            tx_addr_r <= req_addr[int'(pick_idx_s)*NEC_BITS +: NEC_BITS];
            tx_cmd_r  <= req_cmd[int'(pick_idx_s)*NEC_BITS +: NEC_BITS];
            ptr_r     <= ptr_next_s;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_LOAD: begin
          state_r <= ST_SEND;
          tx_en_r <= 1'b1;
          cnt_r   <= '0;
        end
        ST_SEND: begin
          if (cnt_r == CNT_W'(SLOT_CYC - 1)) begin
            state_r <= ST_GAP;
            tx_en_r <= 1'b0;
            grant_r <= '0;
            done_r  <= grant_r;
            gap_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_r == GAP_W'(GAP_CYC - 1)) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            gap_r <= gap_r + GAP_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          tx_en_r <= 1'b0;
          grant_r <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign grant   = grant_r;
  assign done    = done_r;
  assign tx_addr = tx_addr_r;
  assign tx_cmd  = tx_cmd_r;
  assign tx_en   = tx_en_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_ir_tx_arbiter.sv
// Directed bench for ir_tx_arbiter (round-robin build, SLOT_CYC=1000, GAP_CYC=16).
module tb_ir_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_addr;
  logic [31:0] req_cmd;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [7:0]  tx_addr;
  logic [7:0]  tx_cmd;
  logic        tx_en;
  logic        busy;

  localparam logic [31:0] ADDR_TBL = {8'hA3, 8'h10, 8'hA1, 8'hA0};
  localparam logic [31:0] CMD_TBL  = {8'hC3, 8'hD8, 8'hC1, 8'hC0};

  int n_cmp    = 0;
  int n_err    = 0;
  int cyc      = 0;
  int fall_cyc = 0;

  ir_tx_arbiter #(
    .CLK_HZ   (1_000_000),
    .N_REQ    (4),
    .FRAME_MS (1),
    .GAP_CYC  (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .req_cmd  (req_cmd),
    .grant    (grant),
    .done     (done),
    .tx_addr  (tx_addr),
    .tx_cmd   (tx_cmd),
    .tx_en    (tx_en),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // gap_mode: 0 = no gap check, 1 = low time exactly 18, 2 = low time at least 18
  task automatic do_slot(input string tag, input logic [3:0] exp_g, input logic [7:0] exp_a,
                         input logic [7:0] exp_c, input int gap_mode, input bit do_mid,
                         input logic [3:0] mid_req, input logic [31:0] mid_addr);
    int n;
    int hi;
    int low;
    bit stable_ok;
    bit onehot_ok;
    n = 0;
    while (grant == 4'b0000 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_grant_wait"}, 32'(n < 40), 32'd1);
    chk({tag, "_grant"}, 32'(grant), 32'(exp_g));
    step();
    chk({tag, "_tx_en_rise"}, 32'(tx_en), 32'd1);
    low = cyc - fall_cyc;
    if (gap_mode == 1) begin
      chk({tag, "_gap_exact"}, 32'(low), 32'd18);
    end else if (gap_mode == 2) begin
      chk({tag, "_gap_min"}, 32'(low >= 18), 32'd1);
    end
    chk({tag, "_tx_addr"}, 32'(tx_addr), 32'(exp_a));
    chk({tag, "_tx_cmd"}, 32'(tx_cmd), 32'(exp_c));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    hi = 1;
    stable_ok = 1'b1;
    onehot_ok = 1'b1;
    while (hi < 1100) begin
      step();
      if (!tx_en) break;
      hi++;
      if (tx_addr !== exp_a || tx_cmd !== exp_c) stable_ok = 1'b0;
      if ($countones(grant) != 1) onehot_ok = 1'b0;
      if (do_mid && hi == 500) begin
        req      = mid_req;
        req_addr = mid_addr;
      end
    end
    chk({tag, "_slot_len"}, 32'(hi), 32'd1000);
    chk({tag, "_fields_stable"}, 32'(stable_ok), 32'd1);
    chk({tag, "_grant_onehot"}, 32'(onehot_ok), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'(exp_g));
    chk({tag, "_grant_clr"}, 32'(grant), 32'd0);
    fall_cyc = cyc;
    step();
    chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    bit done_seen;
    rst      = 1'b1;
    req      = 4'hF;
    req_addr = ADDR_TBL;
    req_cmd  = CMD_TBL;

    // reset with all requesters asserting
    for (int i = 0; i < 3; i++) step();
    chk("rst_outputs", {grant, done, tx_addr, tx_cmd, 2'b00, tx_en, busy}, 32'd0);

    // continuous req=F: round-robin 0,1,2,3,0 with exact 18-cycle gaps
    rst = 1'b0;
    do_slot("rr0", 4'b0001, 8'hA0, 8'hC0, 0, 1'b0, 4'h0, ADDR_TBL);
    do_slot("rr1", 4'b0010, 8'hA1, 8'hC1, 1, 1'b0, 4'h0, ADDR_TBL);
    do_slot("rr2", 4'b0100, 8'h10, 8'hD8, 1, 1'b0, 4'h0, ADDR_TBL);
    do_slot("rr3", 4'b1000, 8'hA3, 8'hC3, 1, 1'b0, 4'h0, ADDR_TBL);
    do_slot("rr4", 4'b0001, 8'hA0, 8'hC0, 1, 1'b0, 4'h0, ADDR_TBL);
    req = 4'h0;
    for (int i = 0; i < 20; i++) step();
    chk("idle_busy", 32'(busy), 32'd0);

    // single requester 2
    req = 4'b0100;
    do_slot("single2", 4'b0100, 8'h10, 8'hD8, 2, 1'b0, 4'h0, ADDR_TBL);
    req = 4'h0;

    // req[1] held, req[0] raised mid-slot: index 0 must win next
    req = 4'b0010;
    do_slot("late_a", 4'b0010, 8'hA1, 8'hC1, 2, 1'b1, 4'b0011, ADDR_TBL);
    do_slot("late_b", 4'b0001, 8'hA0, 8'hC0, 1, 1'b0, 4'h0, ADDR_TBL);
    req = 4'h0;

    // req[3] dropped and its address changed mid-slot: latched values hold
    req = 4'b1000;
    do_slot("drop3", 4'b1000, 8'hA3, 8'hC3, 2, 1'b1, 4'h0, {8'h5A, ADDR_TBL[23:0]});
    req_addr = ADDR_TBL;

    // reset in the middle of a slot
    req = 4'b0100;
    n = 0;
    while (grant == 4'b0000 && n < 40) begin
      step();
      n++;
    end
    chk("rstmid_grant", 32'(grant), 32'b0100);
    step();
    for (int i = 1; i < 500; i++) step();
    chk("rstmid_tx_before", 32'(tx_en), 32'd1);
    rst = 1'b1;
    step();
    chk("rstmid_tx_en", 32'(tx_en), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_grant_clr", 32'(grant), 32'd0);
    rst = 1'b0;
    req = 4'h0;
    done_seen = (done != 4'b0000);
    for (int i = 0; i < 30; i++) begin
      step();
      if (done != 4'b0000) done_seen = 1'b1;
    end
    chk("rstmid_no_done", 32'(done_seen), 32'd0);
    chk("rstmid_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
